adder_chunk_seq: RTL and testbench
==================================

# adder_chunk_seq

Multi-cycle sequencer sitting directly upstream of the adder slice core. It accepts full-width operands over a valid/ready handshake and feeds them CHUNK bits per cycle through one CHUNK-wide adder, registering the carry between chunks. It returns the full-width sum, carry-out and signed overflow over a second valid/ready handshake. This trades latency for area on wide datapaths while reusing the package's ARCH selection for the slice adder.

## Interface
- WIDTH, 64: operand/sum width; must be a multiple of CHUNK (elaboration error otherwise).
- CHUNK, 16: slice width per cycle; NCHUNK = WIDTH/CHUNK.
- ARCH, adder_pkg::ARCH_RCA: slice adder architecture, passed to the sub-module.
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  operand accept.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry-in.
- out_valid  out  1  result valid.
- out_ready  in  1  result accept.
- out_sum  out  WIDTH  sum, registered.
- out_cout  out  1  carry-out of MSB.
- out_ovf  out  1  signed overflow.
- busy  out  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. When in_valid&in_ready: capture in_a, in_b, in_cin into operand regs, clear idx and the sum reg, carry reg := in_cin, go RUN.
- RUN: slice idx of A and B plus carry reg goes to the slice adder. Write the result to sum bits [idx*CHUNK +: CHUNK] and the slice carry-out to the carry reg. If idx==NCHUNK-1, go DONE, else idx++.
- On the final chunk, register out_cout = slice carry-out and out_ovf = (a[WIDTH-1]==b[WIDTH-1]) && (sum[WIDTH-1]!=a[WIDTH-1]).
- DONE: out_valid=1. out_sum/out_cout/out_ovf are held stable until out_valid&out_ready. On that handshake, go IDLE.
- in_ready=0 in RUN and DONE (unless ADDER_SEQ_B2B_EN). Input changes while not ready are ignored.
- idx width: max(1, adder_pkg::clog2(NCHUNK)). NCHUNK==1 is legal: RUN lasts one cycle.
- All arithmetic is unsigned modulo 2^WIDTH. Overflow is signed interpretation only.
- Reset (any state, including mid-RUN): state=IDLE, in-flight op discarded. out_valid=0, busy=0, out_sum=0, out_cout=0, out_ovf=0, idx=0, carry reg=0. in_ready reads 1 once rst deasserts.

## Timing
- Accept edge T0. RUN occupies cycles T0+1..T0+NCHUNK. out_valid rises after edge T0+NCHUNK, so latency = NCHUNK cycles from accept to out_valid.
- Minimum initiation interval: NCHUNK+2 cycles without the macro (one DONE cycle and one IDLE cycle). With the macro it is NCHUNK+1.
- out_* are registered. Combinational paths: only in_ready/out_valid from state (plus out_ready with the macro).
- Backpressure: out_ready low holds DONE indefinitely with outputs stable.

## Configuration
- ADDER_SEQ_B2B_EN defined: in DONE, in_ready = out_ready. A simultaneous output handshake and input handshake in the same cycle captures the new operands and goes directly to RUN, skipping IDLE.
- Not defined: the output handshake always returns to IDLE, and input is accepted no earlier than the following cycle.

## Structure
- Add to adder_pkg: typedef enum for FSM states (adder_seq_state_t) and localparam ADDER_SEQ_DEF_CHUNK=16. Reuse the ARCH_* constants and clog2.
- One sub-module: adder_chunk_add, a combinational CHUNK-bit a+b+cin -> {cout,sum}, selected by ARCH. It is instantiated once.

## Test plan
- WIDTH=64, CHUNK=16: a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0 -> out_sum=0, out_cout=1, out_ovf=0, out_valid exactly 4 cycles after accept.
- a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> out_sum=0x8000_0000_0000_0000, out_cout=0, out_ovf=1.
- a=0, b=0, cin=1 -> out_sum=1, out_cout=0. Also a=0x0000_0000_0001_FFFF, b=1 -> out_sum=0x0000_0000_0002_0000, checking the inter-chunk carry.
- out_ready held low 10 cycles in DONE -> out_valid stays 1, out_sum stable, in_ready=0, busy=1. Releasing out_ready completes the handshake and busy falls.
- rst pulsed after 2 RUN cycles -> out_valid=0, busy=0, out_sum=0 immediately. The next op, 5+7, gives out_sum=12.
- Two ops with in_valid held and out_ready=1 -> with ADDER_SEQ_B2B_EN, second accept on the first result's handshake cycle (interval 5). Without it, interval 6 with one IDLE cycle.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared adder definitions: architecture selectors, sequencer FSM states, clog2 helper.
package adder_pkg;

    localparam int ARCH_RCA = 0;
    localparam int ARCH_CLA = 1;
    localparam int ARCH_BEH = 2;

    localparam int ADDER_SEQ_DEF_CHUNK = 16;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_RUN,
        SEQ_DONE
    } adder_seq_state_t;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >>> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/adder_chunk_add.sv
// Combinational CHUNK-bit adder {cout,sum} = a + b + cin; structure chosen by ARCH.
module adder_chunk_add
    import adder_pkg::*;
#(
    parameter int CHUNK = ADDER_SEQ_DEF_CHUNK,
    parameter int ARCH  = ARCH_RCA
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    generate
        if (ARCH == ARCH_RCA) begin : g_rca
            logic [CHUNK:0] c;
            always_comb begin
                c    = '0;
                c[0] = cin;
                for (int unsigned i = 0; i < CHUNK; i++)
                    c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
            end
            assign sum  = a ^ b ^ c[CHUNK-1:0];
            assign cout = c[CHUNK];
        end else if (ARCH == ARCH_CLA) begin : g_cla
            // Kogge-Stone prefix; cin folded into bit 0's generate.
            // Descending i keeps gg[i-d]/pp[i-d] at the previous stage's values.
            logic [CHUNK-1:0] p0;
            logic [CHUNK-1:0] gg;
            logic [CHUNK-1:0] pp;
            logic [CHUNK:0]   c;
            always_comb begin
                p0    = a ^ b;
                gg    = a & b;
                pp    = p0;
                gg[0] = gg[0] | (p0[0] & cin);
                for (int unsigned d = 1; d < CHUNK; d = d * 2) begin
                    for (int unsigned i = CHUNK - 1; i >= d; i--) begin
                        gg[i] = gg[i] | (pp[i] & gg[i-d]);
                        pp[i] = pp[i] & pp[i-d];
                    end
                end
                c = {gg, cin};
            end
            assign sum  = p0 ^ c[CHUNK-1:0];
            assign cout = c[CHUNK];
        end else begin : g_beh
            assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
        end
    endgenerate

endmodule

// File: rtl/adder_chunk_seq.sv
// Multi-cycle wide adder: feeds CHUNK bits per cycle through one slice adder.
// Optional macro ADDER_SEQ_B2B_EN: accept new operands on the result handshake cycle.
module adder_chunk_seq
    import adder_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CHUNK = ADDER_SEQ_DEF_CHUNK,
    parameter int ARCH  = ARCH_RCA
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (clog2(NCHUNK) > 1) ? clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

    generate
        if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
            $error("adder_chunk_seq: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    adder_seq_state_t state, nstate;

    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             carry_q, cout_q, ovf_q;
    logic [IDXW-1:0]  idx;
    logic [CHUNK-1:0] a_slice, b_slice, slice_sum;
    logic             slice_cout;
    logic             accept;

    assign a_slice = CHUNK'(a_q >> (CHUNK * int'(idx)));
    assign b_slice = CHUNK'(b_q >> (CHUNK * int'(idx)));

    adder_chunk_add #(
        .CHUNK (CHUNK),
        .ARCH  (ARCH)
    ) u_add (
        .a    (a_slice),
        .b    (b_slice),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= SEQ_IDLE;
        else     state <= nstate;
    end

    always_comb begin
        nstate    = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            SEQ_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) nstate = SEQ_RUN;
            end
            SEQ_RUN: begin
                busy = 1'b1;
                if (idx == LAST) nstate = SEQ_DONE;
            end
            SEQ_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
`ifdef ADDER_SEQ_B2B_EN
                in_ready = out_ready;
                if (out_ready) nstate = in_valid ? SEQ_RUN : SEQ_IDLE;
`else
                if (out_ready) nstate = SEQ_IDLE;
`endif
            end
            default: nstate = SEQ_IDLE;
        endcase
    end

    assign accept = in_valid & in_ready;

    // Sum reg is cleared on accept, so each chunk can simply be OR-ed into place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            idx     <= '0;
        end else if (accept) begin
            a_q     <= in_a;
            b_q     <= in_b;
            carry_q <= in_cin;
            sum_q   <= '0;
            idx     <= '0;
        end else if (state == SEQ_RUN) begin
            sum_q   <= sum_q | (WIDTH'(slice_sum) << (CHUNK * int'(idx)));
            carry_q <= slice_cout;
            if (idx == LAST) begin
                cout_q <= slice_cout;
                ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                          (slice_sum[CHUNK-1] != a_q[WIDTH-1]);
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign out_sum  = sum_q;
    assign out_cout = cout_q;
    assign out_ovf  = ovf_q;

endmodule

// File: tb/tb_adder_chunk_seq.sv
// Directed scoreboard bench for adder_chunk_seq (WIDTH=64, CHUNK=16).
module tb_adder_chunk_seq;
    import adder_pkg::*;

    localparam int W = 64;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, in_cin;
    logic [W-1:0] in_a, in_b;
    logic         out_valid, out_ready, out_cout, out_ovf, busy;
    logic [W-1:0] out_sum;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    adder_chunk_seq #(
        .WIDTH (W),
        .CHUNK (16),
        .ARCH  (ARCH_RCA)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        logic [W:0] t;
        exp_t       e;
        t      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        e.sum  = t[W-1:0];
        e.cout = t[W];
        e.ovf  = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
        q.push_back(e);
    endtask

    // Returns at the negedge following the accept edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        output int acc_edge);
        int n;
        @(negedge clk);
        in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", in_ready, 1);
        if (in_ready) push_exp(a, b, cin);
        acc_edge = cyc + 1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic recv(input string tag, input int acc_edge, input bit check_lat);
        int   n;
        exp_t e;
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, out_valid, 1);
        if (check_lat) chk({tag, "_latency"}, W'(cyc - acc_edge), W'(N));
        if (q.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = q.pop_front();
            chk({tag, "_sum"},  out_sum,  e.sum);
            chk({tag, "_cout"}, out_cout, e.cout);
            chk({tag, "_ovf"},  out_ovf,  e.ovf);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_busy_after"}, busy, 0);
    endtask

    initial begin
        int   acc, acc1, acc2, nacc, nres;
        bit   pend;
        exp_t e;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_cin = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy",      busy,      0);
        chk("rst_out_sum",   out_sum,   0);
        chk("rst_out_cout",  out_cout,  0);
        chk("rst_out_ovf",   out_ovf,   0);
        rst = 1'b0;
        #1 chk("rst_in_ready", in_ready, 1);

        send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, acc);
        recv("allones_plus1", acc, 1);
        chk("allones_sum_zero", out_sum, 0);
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, acc);
        recv("maxpos_plus1", acc, 1);
        send(64'd0, 64'd0, 1'b1, acc);
        recv("cin_only", acc, 1);
        send(64'h0000_0000_0001_FFFF, 64'd1, 1'b0, acc);
        recv("chunk_carry", acc, 1);
        for (int i = 0; i < 3; i++) begin
            send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), acc);
            recv("random", acc, 1);
        end

        // Backpressure: hold DONE for 10 cycles.
        send(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3211, 1'b1, acc);
        recv_wait: for (int n = 0; n < 50 && !out_valid; n++) @(negedge clk);
        e = (q.size() > 0) ? q[0] : '0;
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid",    out_valid, 1);
            chk("bp_sum",      out_sum,   e.sum);
            chk("bp_in_ready", in_ready,  0);
            chk("bp_busy",     busy,      1);
            @(negedge clk);
        end
        recv("bp_release", acc, 0);

        // Asynchronous reset two RUN cycles into an operation.
        send(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 1'b0, acc);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy",      busy,      0);
        chk("midrst_out_sum",   out_sum,   0);
        chk("midrst_out_cout",  out_cout,  0);
        if (q.size() > 0) void'(q.pop_back());
        @(negedge clk);
        rst = 1'b0;
        #1 chk("midrst_in_ready", in_ready, 1);
        send(64'd5, 64'd7, 1'b0, acc);
        recv("after_rst", acc, 1);

        // Two ops with in_valid held and out_ready high.
        @(negedge clk);
        out_ready = 1'b1;
        in_a = 64'd100; in_b = 64'd23; in_cin = 1'b0; in_valid = 1'b1;
        nacc = 0; nres = 0; pend = 1'b0; acc1 = 0; acc2 = 0;
        for (int n = 0; n < 60 && nres < 2; n++) begin
            if (pend) begin
                if (nacc == 1) begin
                    in_a = 64'hFFFF_0000_FFFF_0000; in_b = 64'h0001_0000_0001_0000; in_cin = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
                pend = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("b2b_sb_empty", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("b2b_sum",  out_sum,  e.sum);
                    chk("b2b_cout", out_cout, e.cout);
                end
                nres++;
            end
            if (in_valid && in_ready) begin
                push_exp(in_a, in_b, in_cin);
                nacc++;
                if (nacc == 1) acc1 = cyc + 1;
                else           acc2 = cyc + 1;
                pend = 1'b1;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("b2b_results", W'(nres), 2);
`ifdef ADDER_SEQ_B2B_EN
        chk("b2b_interval", W'(acc2 - acc1), W'(N + 1));
`else
        chk("b2b_interval", W'(acc2 - acc1), W'(N + 2));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
